// File: rtl/controlador_estados_if.sv
// Bus between the pet state controller and its environment: user buttons,
// attribute values and death flag in; one-hot state and action-done pulse out.
interface controlador_estados_if;
    logic       btn_dormir;
    logic       btn_comer;
    logic       btn_aula;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic       morreu;
    logic [3:0] estado;
    logic       acao_concluida;

    modport master (
        output btn_dormir, btn_comer, btn_aula,
        output fome, felicidade, sono, morreu,
        input  estado, acao_concluida
    );

    modport slave (
        input  btn_dormir, btn_comer, btn_aula,
        input  fome, felicidade, sono, morreu,
        output estado, acao_concluida
    );
endinterface

// File: rtl/controlador_estados.sv
// Pet state controller: idle / sleeping / eating / lecturing / dead, with
// edge-detected buttons, timed actions, saturation exit and forced sleep.
module controlador_estados #(
    parameter logic [15:0] DURACAO        = 16'd50000,
    parameter logic [7:0]  LIMIAR_DESMAIO = 8'd20,
    parameter logic [7:0]  MAX_ATRIB      = 8'd100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    controlador_estados_if.slave  bus
);

    typedef enum logic [3:0] {
        OCIOSO     = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    localparam logic [15:0] DUR_EF = (DURACAO == 16'd0) ? 16'd1 : DURACAO;

    estado_t     estado_q, estado_d;
    logic        conclui_q, conclui_d;
    logic [15:0] cont_q, cont_d;
    logic [2:0]  btn_now, btn_hist_q, btn_lock_q, press;
    logic        fim_tempo, saturado, cancelar, sono_baixo;

    assign btn_now = {bus.btn_aula, bus.btn_comer, bus.btn_dormir};

    // A button held through reset stays locked until it is seen released,
    // so it cannot masquerade as a fresh press after reset.
    assign press = btn_now & ~btn_hist_q & ~btn_lock_q;

    assign fim_tempo  = (cont_q == DUR_EF - 16'd1);
    assign sono_baixo = (bus.sono <= LIMIAR_DESMAIO);

    assign saturado = ((estado_q == DORMINDO)   && (bus.sono       >= MAX_ATRIB)) ||
                      ((estado_q == COMENDO)    && (bus.fome       >= MAX_ATRIB)) ||
                      ((estado_q == DANDO_AULA) && (bus.felicidade >= MAX_ATRIB));

    assign cancelar = ((estado_q == DORMINDO)   && press[0]) ||
                      ((estado_q == COMENDO)    && press[1]) ||
                      ((estado_q == DANDO_AULA) && press[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            conclui_q  <= 1'b0;
            cont_q     <= 16'd0;
            btn_hist_q <= 3'b000;
            btn_lock_q <= 3'b111;
        end else begin
            estado_q   <= estado_d;
            conclui_q  <= conclui_d;
            cont_q     <= cont_d;
            btn_hist_q <= btn_now;
            btn_lock_q <= btn_lock_q & btn_now;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        conclui_d = 1'b0;
        cont_d    = 16'd0;
        if (bus.morreu) begin
            estado_d = MORTO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (press[0])                      estado_d = DORMINDO;
                    else if (press[1])                 estado_d = COMENDO;
                    else if (press[2] && !sono_baixo)  estado_d = DANDO_AULA;
                    else if (sono_baixo)               estado_d = DORMINDO;
                end
                DORMINDO, COMENDO, DANDO_AULA: begin
                    if (fim_tempo || saturado) begin
                        estado_d  = OCIOSO;
                        conclui_d = 1'b1;
                    end else if (cancelar) begin
                        estado_d = OCIOSO;
                    end else begin
                        cont_d = cont_q + 16'd1;
                    end
                end
                MORTO:   estado_d = MORTO;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    assign bus.estado         = estado_q;
    assign bus.acao_concluida = conclui_q;

endmodule

// File: tb/tb_controlador_estados.sv
// Directed bench for controlador_estados with DURACAO=8: timed action,
// saturation, cancel, forced sleep, death and reset behaviour.
module tb_controlador_estados;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    controlador_estados_if bus_if ();

    controlador_estados #(
        .DURACAO        (16'd8),
        .LIMIAR_DESMAIO (8'd20),
        .MAX_ATRIB      (8'd100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [3:0] est, input logic ac);
        check({tag, ".estado"}, {4'b0, bus_if.estado}, {4'b0, est});
        check({tag, ".acao"}, {7'b0, bus_if.acao_concluida}, {7'b0, ac});
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.btn_dormir = 1'b0;
        bus_if.btn_comer  = 1'b0;
        bus_if.btn_aula   = 1'b0;
        bus_if.fome       = 8'd50;
        bus_if.felicidade = 8'd50;
        bus_if.sono       = 8'd50;
        bus_if.morreu     = 1'b0;

        #3;
        chk_st("reset", 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_st("post_reset", 4'b0000, 1'b0);

        // Full-length eat action: 8 visible cycles then a one-cycle pulse.
        bus_if.btn_comer = 1'b1;
        tick();
        bus_if.btn_comer = 1'b0;
        chk_st("comer_c1", 4'b0010, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk_st($sformatf("comer_c%0d", i), 4'b0010, 1'b0);
        end
        tick();
        chk_st("comer_fim", 4'b0000, 1'b1);
        tick();
        chk_st("comer_pos", 4'b0000, 1'b0);

        // Saturation exit while the button stays held.
        bus_if.btn_comer = 1'b1;
        tick();
        chk_st("sat_ent", 4'b0010, 1'b0);
        tick();
        tick();
        chk_st("sat_c3", 4'b0010, 1'b0);
        bus_if.fome = 8'd100;
        tick();
        chk_st("sat_fim", 4'b0000, 1'b1);
        bus_if.fome = 8'd50;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk_st($sformatf("segura_%0d", i), 4'b0000, 1'b0);
        end
        bus_if.btn_comer = 1'b0;
        tick();

        // Simultaneous dormir+aula, foreign press ignored, own press cancels.
        bus_if.btn_dormir = 1'b1;
        bus_if.btn_aula   = 1'b1;
        tick();
        chk_st("simul", 4'b0001, 1'b0);
        bus_if.btn_dormir = 1'b0;
        bus_if.btn_aula   = 1'b0;
        tick();
        bus_if.btn_aula = 1'b1;
        tick();
        chk_st("aula_ign", 4'b0001, 1'b0);
        bus_if.btn_aula = 1'b0;
        tick();
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("cancela", 4'b0000, 1'b0);
        bus_if.btn_dormir = 1'b0;
        tick();
        chk_st("cancela_pos", 4'b0000, 1'b0);

        // Forced sleep, and lecture refused while sleepy.
        bus_if.sono = 8'd15;
        tick();
        chk_st("desmaio", 4'b0001, 1'b0);
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("desm_cancel", 4'b0000, 1'b0);
        bus_if.btn_dormir = 1'b0;
        bus_if.btn_aula   = 1'b1;
        tick();
        chk_st("aula_sono", 4'b0001, 1'b0);
        bus_if.btn_aula   = 1'b0;
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("desm_cancel2", 4'b0000, 1'b0);
        bus_if.btn_dormir = 1'b0;
        bus_if.sono       = 8'd21;
        tick();
        chk_st("sono_21", 4'b0000, 1'b0);
        bus_if.sono = 8'd20;
        tick();
        chk_st("sono_20", 4'b0001, 1'b0);
        tick();
        bus_if.sono = 8'd100;
        tick();
        chk_st("sono_sat", 4'b0000, 1'b1);
        bus_if.sono = 8'd50;
        tick();
        chk_st("sono_ok", 4'b0000, 1'b0);

        // Death from DANDO_AULA, buttons ignored, asynchronous reset.
        bus_if.btn_aula = 1'b1;
        tick();
        chk_st("aula", 4'b0100, 1'b0);
        bus_if.btn_aula = 1'b0;
        tick();
        bus_if.morreu = 1'b1;
        tick();
        chk_st("morto", 4'b1000, 1'b0);
        bus_if.morreu     = 1'b0;
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("morto_btn1", 4'b1000, 1'b0);
        bus_if.btn_dormir = 1'b0;
        bus_if.btn_aula   = 1'b1;
        tick();
        chk_st("morto_btn2", 4'b1000, 1'b0);
        bus_if.btn_aula = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_st("rst_async", 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_st("rst_solto", 4'b0000, 1'b0);

        // Reset mid-sleep with the button held, then held through release.
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("dorm_ent", 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk_st("dorm_c4", 4'b0001, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_st("rst_meio", 4'b0000, 1'b0);
        tick();
        chk_st("rst_meio_clk", 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_st($sformatf("retido_%0d", i), 4'b0000, 1'b0);
        end
        bus_if.btn_dormir = 1'b0;
        tick();
        chk_st("solto", 4'b0000, 1'b0);
        bus_if.btn_dormir = 1'b1;
        tick();
        chk_st("nova_press", 4'b0001, 1'b0);
        bus_if.btn_dormir = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/controlador_estados.md
CONTROLADOR_ESTADOS -- requirements
Module: controlador_estados

Interface
REQ-001 Parameter DURACAO, default 16'd50000, cycles an action (sleep/eat/lecture) lasts if not ended early.
REQ-002 Parameter LIMIAR_DESMAIO, default 8'd20, sono at or below this while idle forces DORMINDO.
REQ-003 Parameter MAX_ATRIB, default 8'd100, attribute value that ends the matching action early (saturation).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_dormir, btn_comer, btn_aula  input  1 each  synchronous user button levels.
REQ-007 fome, felicidade, sono  input  8 each  attribute values from the attribute controller.
REQ-008 morreu  input  1  death flag from the attribute controller.
REQ-009 estado  output  4  one-hot state: OCIOSO 4'b0000, DORMINDO 4'b0001, COMENDO 4'b0010, DANDO_AULA 4'b0100, MORTO 4'b1000.
REQ-010 acao_concluida  output  1  one-cycle pulse when an action ends by timeout or saturation.

Function
REQ-011 Each button SHALL be registered every cycle; press = btn high AND registered previous value low; only presses act, held levels do not repeat.
REQ-012 Per-cycle priority SHALL be: morreu > action end > cancel > start > forced sleep; one transition per cycle at most.
REQ-013 morreu=1 in any state SHALL move estado to MORTO at the next edge; MORTO is absorbing until rst_n asserted; buttons ignored.
REQ-014 In OCIOSO, a press SHALL start the action at the same edge; simultaneous presses resolve dormir > comer > aula.
REQ-015 Action counter (16 bit) SHALL clear to 0 on entry to any action and increment by 1 each cycle in that action.
REQ-016 When counter == DURACAO-1, estado SHALL return to OCIOSO at the next edge, so the action is visible exactly DURACAO cycles.
REQ-017 Saturation: DORMINDO with sono >= MAX_ATRIB, COMENDO with fome >= MAX_ATRIB, DANDO_AULA with felicidade >= MAX_ATRIB SHALL return to OCIOSO at the next edge.
REQ-018 acao_concluida SHALL be 1 for exactly the cycle after a REQ-016 or REQ-017 exit (registered with estado), 0 otherwise.
REQ-019 A press of the same button as the active action SHALL cancel it (to OCIOSO, acao_concluida stays 0); presses of other buttons during an action SHALL be ignored.
REQ-020 In OCIOSO with no press and sono <= LIMIAR_DESMAIO, estado SHALL enter DORMINDO (counter cleared) at the next edge.
REQ-021 DANDO_AULA SHALL NOT start while sono <= LIMIAR_DESMAIO; the press is dropped and forced sleep applies.
REQ-022 DURACAO == 0 SHALL be treated as 1.
REQ-023 estado SHALL never hold a non-listed encoding; any such value SHALL recover to OCIOSO next edge.

Reset
REQ-024 rst_n low SHALL immediately force estado=OCIOSO, acao_concluida=0, counter=0, button history registers=0, independent of clk.
REQ-025 Reset mid-action SHALL abort without an acao_concluida pulse; after release, a still-held button SHALL NOT count as a press until released and pressed again.
REQ-026 First transition after release SHALL occur at the first posedge with rst_n high.

Verification (bench DURACAO=8, LIMIAR_DESMAIO=20, MAX_ATRIB=100)
REQ-027 sono=50, fome=50, pulse btn_comer 1 cycle -> estado=0010 for 8 cycles, then 0000 with acao_concluida=1 for one cycle.
REQ-028 In COMENDO, drive fome=100 at cycle 3 -> estado=0000 next edge, acao_concluida=1; hold btn_comer high 20 cycles -> only one action.
REQ-029 btn_dormir and btn_aula rise same cycle -> estado=0001; btn_aula press during DORMINDO ignored; btn_dormir press cancels -> 0000, acao_concluida=0.
REQ-030 Idle, sono=15 -> estado=0001 next edge; btn_aula press with sono=15 -> no DANDO_AULA.
REQ-031 In DANDO_AULA assert morreu -> estado=1000 next edge; buttons ignored; rst_n low asynchronously -> 0000 before next clk edge.
REQ-032 Assert rst_n low at counter=4 in DORMINDO with btn_dormir held -> 0000, no pulse; release rst_n with button held -> stays 0000 until new press.
